led_flow_ctrl: RTL

//  Parametrised multi-mode LED chaser. Drives an active-low LED bank from a

---
 rtl/led_flow_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/led_flow_ctrl.sv
// led_flow_ctrl: multi-mode LED chaser with prescaled step tick.
// Drives an active-low LED bank in one of four patterns: rotate-up,
// rotate-down, ping-pong or fill bar. Speed and run/hold are selectable at runtime.
// Optional feature macro: LED_FLOW_PWM_EN adds duty-cycle dimming of lit LEDs.
module led_flow_ctrl #(
    parameter int LED_N    = 8,
    parameter int TICK_DIV = 5000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [1:0]               speed,
    input  logic [3:0]               duty,
    output logic                     step,
    output logic [$clog2(LED_N)-1:0] pos,
    output logic [LED_N-1:0]         led
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int PW = $clog2(LED_N);
    localparam int LW = $clog2(LED_N + 1);
    localparam logic [PW-1:0] POS_LAST = PW'(LED_N - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(LED_N);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PING = 2'b10,
        MODE_FILL = 2'b11
    } mode_e;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             step_q, step_d;
    mode_e            mode_q, mode_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic             dir_up_q, dir_up_d;
    logic [LW-1:0]    level_q, level_d;
    logic             started_q, started_d;
    logic [LED_N-1:0] lit_q, lit_d;

    logic [31:0]      period_m1;
    logic             tick;
    logic             restart;
    logic             ping_up;

    // Prescaler, step generation and pattern advance, all decided in one place
    always_comb begin
        cnt_d     = cnt_q;
        step_d    = 1'b0;
        mode_d    = mode_q;
        pos_d     = pos_q;
        dir_up_d  = dir_up_q;
        level_d   = level_q;
        started_d = started_q;
        lit_d     = lit_q;
        restart   = 1'b0;
        ping_up   = dir_up_q;
        period_m1 = (32'(TICK_DIV) >> speed) - 32'd1;
        tick      = en && (32'(cnt_q) >= period_m1);

        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end

        if (tick) begin
            step_d    = 1'b1;
            started_d = 1'b1;
            mode_d    = mode_e'(mode);
            restart   = !started_q || (mode_e'(mode) != mode_q);

            // The direction is forced at the endpoints so each end is shown once
            if (pos_q == POS_LAST) begin
                ping_up = 1'b0;
            end else if (pos_q == '0) begin
                ping_up = 1'b1;
            end

            case (mode_e'(mode))
                MODE_UP: begin
                    if (restart || pos_q == POS_LAST) pos_d = '0;
                    else                              pos_d = pos_q + PW'(1);
                end
                MODE_DOWN: begin
                    if (restart || pos_q == '0) pos_d = POS_LAST;
                    else                        pos_d = pos_q - PW'(1);
                end
                MODE_PING: begin
                    if (restart) begin
                        pos_d    = '0;
                        dir_up_d = 1'b1;
                    end else begin
                        pos_d    = ping_up ? pos_q + PW'(1) : pos_q - PW'(1);
                        dir_up_d = ping_up;
                    end
                end
                default: begin
                    if (restart)                  level_d = LW'(1);
                    else if (level_q == LVL_FULL) level_d = '0;
                    else                          level_d = level_q + LW'(1);
                    pos_d = (level_d == '0) ? '0 : PW'(level_d - LW'(1));
                end
            endcase

            for (int i = 0; i < LED_N; i++) begin
                if (mode_e'(mode) == MODE_FILL) lit_d[i] = (i < int'(level_d));
                else                            lit_d[i] = (pos_d == PW'(i));
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            step_q    <= 1'b0;
            mode_q    <= MODE_UP;
            pos_q     <= '0;
            dir_up_q  <= 1'b1;
            level_q   <= '0;
            started_q <= 1'b0;
            lit_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            mode_q    <= mode_d;
            pos_q     <= pos_d;
            dir_up_q  <= dir_up_d;
            level_q   <= level_d;
            started_q <= started_d;
            lit_q     <= lit_d;
        end
    end

    assign step = step_q;
    assign pos  = pos_q;

`ifdef LED_FLOW_PWM_EN
    logic [3:0] pwm_q, pwm_d;

    // Free-running dimming counter, independent of run/hold
    always_comb begin
        pwm_d = pwm_q + 4'd1;
    end

    // Dimming counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pwm_q <= 4'd0;
        else      pwm_q <= pwm_d;
    end

    assign led = ~lit_q | {LED_N{~(pwm_q < duty)}};
`else
    logic unused_duty;
    assign unused_duty = ^duty;
    assign led = ~lit_q;
`endif

endmodule
